// File: rtl/header_writer_pkg.sv
// header_writer_pkg
//   Shared definitions for the egress header writer: IOQ module-header
//   constants, Ethernet/IPv4 field positions within 64-bit packet words,
//   FSM state encoding, the rewrite descriptor layout and the RFC 1624
//   checksum patch used when the TTL is decremented.
package header_writer_pkg;

    localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hff;
    localparam int unsigned IOQ_DST_PORT_POS   = 48;

    // Word indices counted from the first ctrl==0 word of the packet
    localparam logic [2:0] WORD_ETH_DA  = 3'd1;
    localparam logic [2:0] WORD_ETH_SA  = 3'd2;
    localparam logic [2:0] WORD_IP_TTL  = 3'd3;
    localparam logic [2:0] WORD_IP_CSUM = 3'd4;
    localparam logic [2:0] WORD_CNT_MAX = 3'd5;

    localparam int unsigned MAC_DA_LSB    = 16;
    localparam int unsigned MAC_SA_LO_LSB = 32;
    localparam int unsigned TTL_LSB       = 8;
    localparam int unsigned CSUM_LSB      = 48;

    typedef enum logic [1:0] {
        ST_WAIT_INFO  = 2'd0,
        ST_MODULE_HDR = 2'd1,
        ST_ETH_IP     = 2'd2,
        ST_PAYLOAD    = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] dst_port;
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic        dec_ttl;
        logic        drop;
    } rw_desc_t;

    localparam int unsigned RW_DESC_W = $bits(rw_desc_t);

    // Incremental checksum update for a TTL decrement: add 0x0100 with a
    // single end-around carry fold.
    function automatic logic [15:0] ttl_dec_csum(input logic [15:0] csum);
        logic [16:0] sum;
        sum = {1'b0, csum} + 17'h0100;
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

endpackage

// File: rtl/header_writer_fallthrough_small_fifo.sv
// fallthrough_small_fifo
//   Small first-word-fall-through FIFO: the head entry is visible on dout
//   whenever empty is low. Writes while full are dropped.
//   Ports: din/wr_en (push), rd_en (pop), dout (head), nearly_full
//   (occupancy >= PROG_FULL_THRESHOLD), empty, reset (async, active-high), clk.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH               = 72,
    parameter int unsigned MAX_DEPTH_BITS      = 3,
    parameter int unsigned PROG_FULL_THRESHOLD = (1 << MAX_DEPTH_BITS) - 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);

    localparam int unsigned AW        = MAX_DEPTH_BITS;
    localparam int unsigned DW        = MAX_DEPTH_BITS + 1;
    localparam int unsigned MAX_DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0] mem_q [MAX_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [DW-1:0]    depth_q;
    logic             full;
    logic             wr;
    logic             rd;

    assign full        = (depth_q == DW'(MAX_DEPTH));
    assign empty       = (depth_q == '0);
    assign nearly_full = (depth_q >= DW'(PROG_FULL_THRESHOLD));
    assign wr          = wr_en && !full;
    assign rd          = rd_en && !empty;
    assign dout        = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            depth_q <= depth_q + DW'(wr) - DW'(rd);
        end
    end

endmodule

// File: rtl/header_writer.sv
// header_writer
//   Applies per-packet forwarding decisions to the NetFPGA packet stream:
//   sets the IOQ destination port, rewrites MAC DA/SA, optionally decrements
//   the IPv4 TTL with an incremental checksum patch, or drops the packet.
//   Optional feature macro: HEADER_WRITER_TTL_DEC_EN (TTL/checksum edit).
//   Ports:
//     clk, reset                   core clock, async active-high reset
//     in_data/in_ctrl/in_wr/in_rdy input packet stream
//     out_data/out_ctrl/out_wr     rewritten stream (registered, 1 cycle)
//     out_rdy                      downstream ready
//     rw_wr/rw_in_rdy              descriptor push / queue not nearly full
//     rw_dst_port, rw_mac_dst, rw_mac_src, rw_dec_ttl, rw_drop  descriptor
module header_writer
    import header_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  rw_wr,
    output logic                  rw_in_rdy,
    input  logic [15:0]           rw_dst_port,
    input  logic [47:0]           rw_mac_dst,
    input  logic [47:0]           rw_mac_src,
    input  logic                  rw_dec_ttl,
    input  logic                  rw_drop
);

    state_t                state_q;
    logic [2:0]            cnt_q;
    rw_desc_t              desc_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic                  out_wr_q;

    rw_desc_t              fifo_din;
    rw_desc_t              fifo_desc;
    rw_desc_t              cur_desc;
    logic                  fifo_empty;
    logic                  fifo_nearly_full;
    logic                  xfer;
    logic                  pop;
    logic [2:0]            word_num;
    logic [DATA_WIDTH-1:0] data_d;

    assign fifo_din = {rw_dst_port, rw_mac_dst, rw_mac_src, rw_dec_ttl, rw_drop};

    fallthrough_small_fifo #(
        .WIDTH          (RW_DESC_W),
        .MAX_DEPTH_BITS (2)
    ) u_rw_fifo (
        .din         (fifo_din),
        .wr_en       (rw_wr),
        .rd_en       (pop),
        .dout        (fifo_desc),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty),
        .reset       (reset),
        .clk         (clk)
    );

    assign rw_in_rdy = !fifo_nearly_full;
    assign in_rdy    = out_rdy && !(state_q == ST_WAIT_INFO && fifo_empty);
    assign xfer      = in_wr && in_rdy;
    // The first word of a packet is accepted directly from ST_WAIT_INFO
    // (only possible with a descriptor queued); it uses the queue head and
    // pops it, so no separate "descriptor ready" state is needed.
    assign pop       = xfer && (state_q == ST_WAIT_INFO);
    assign cur_desc  = (state_q == ST_WAIT_INFO) ? fifo_desc : desc_q;
    assign word_num  = cnt_q + 3'd1;

    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;
    assign out_wr   = out_wr_q;

`ifndef HEADER_WRITER_TTL_DEC_EN
    logic unused_dec_ttl;
    assign unused_dec_ttl = cur_desc.dec_ttl;
`endif

    always_comb begin
        data_d = in_data;
        case (state_q)
            ST_WAIT_INFO, ST_MODULE_HDR: begin
                if (in_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM)) begin
                    data_d[IOQ_DST_PORT_POS +: 16] = cur_desc.dst_port;
                end else if (in_ctrl == '0) begin
                    data_d[63:MAC_DA_LSB] = cur_desc.mac_dst;
                    data_d[15:0]          = cur_desc.mac_src[47:32];
                end
            end
            ST_ETH_IP: begin
                if (word_num == WORD_ETH_SA) begin
                    data_d[MAC_SA_LO_LSB +: 32] = cur_desc.mac_src[31:0];
                end
`ifdef HEADER_WRITER_TTL_DEC_EN
                if (cur_desc.dec_ttl && word_num == WORD_IP_TTL) begin
                    data_d[TTL_LSB +: 8] = in_data[TTL_LSB +: 8] - 8'd1;
                end
                if (cur_desc.dec_ttl && word_num == WORD_IP_CSUM) begin
                    data_d[CSUM_LSB +: 16] = ttl_dec_csum(in_data[CSUM_LSB +: 16]);
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_WAIT_INFO;
            cnt_q      <= '0;
            desc_q     <= '0;
            out_data_q <= '0;
            out_ctrl_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            out_wr_q <= xfer && !cur_desc.drop;
            if (xfer) begin
                out_data_q <= data_d;
                out_ctrl_q <= in_ctrl;
                case (state_q)
                    ST_WAIT_INFO, ST_MODULE_HDR: begin
                        if (state_q == ST_WAIT_INFO) desc_q <= fifo_desc;
                        if (in_ctrl == '0) begin
                            state_q <= ST_ETH_IP;
                            cnt_q   <= WORD_ETH_DA;
                        end else begin
                            state_q <= ST_MODULE_HDR;
                        end
                    end
                    ST_ETH_IP, ST_PAYLOAD: begin
                        if (in_ctrl != '0) begin
                            state_q <= ST_WAIT_INFO;
                            cnt_q   <= '0;
                        end else begin
                            if (cnt_q != WORD_CNT_MAX) cnt_q <= word_num;
                            if (state_q == ST_ETH_IP && word_num == WORD_IP_CSUM) begin
                                state_q <= ST_PAYLOAD;
                            end
                        end
                    end
                    default: state_q <= ST_WAIT_INFO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_header_writer.sv
module tb_header_writer;

    typedef struct packed {
        logic [15:0] dst;
        logic [47:0] da;
        logic [47:0] sa;
        logic        dec;
        logic        drop;
    } desc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic        rw_wr = 1'b0;
    logic        rw_in_rdy;
    logic [15:0] rw_dst_port = '0;
    logic [47:0] rw_mac_dst = '0;
    logic [47:0] rw_mac_src = '0;
    logic        rw_dec_ttl = 1'b0;
    logic        rw_drop = 1'b0;

    logic [63:0] pd[$];
    logic [7:0]  pc[$];
    logic [71:0] exp_q[$];
    logic [71:0] mdl[$];
    logic [71:0] cap[$];
    logic [71:0] exp_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          bp_cyc = 0;
    bit          bp_en = 1'b0;

`ifdef HEADER_WRITER_TTL_DEC_EN
    localparam bit TTL_EN = 1'b1;
`else
    localparam bit TTL_EN = 1'b0;
`endif

    header_writer #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .rw_wr(rw_wr), .rw_in_rdy(rw_in_rdy), .rw_dst_port(rw_dst_port),
        .rw_mac_dst(rw_mac_dst), .rw_mac_src(rw_mac_src),
        .rw_dec_ttl(rw_dec_ttl), .rw_drop(rw_drop)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Output scoreboard
    always @(negedge clk) begin
        if (!reset && out_wr) begin
            cap.push_back({out_ctrl, out_data});
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_wr: got word %h required no output", out_data);
            end else begin
                exp_e = exp_q.pop_front();
                check64("out_data", out_data, exp_e[63:0]);
                check64("out_ctrl", {56'd0, out_ctrl}, {56'd0, exp_e[71:64]});
            end
        end
    end

    function automatic logic [63:0] tmpl_word(input int k, input logic [7:0] ttl, input logic [15:0] csum);
        case (k)
            1:       return 64'hFFFF_FFFF_FFFF_1234;
            2:       return 64'h5678_9ABC_0800_4500;
            3:       return {48'h002E_0000_4000, ttl, 8'h11};
            4:       return {csum, 48'hC0A8_0001_C0A8};
            5:       return 64'h0002_1111_2222_3333;
            default: return 64'h4444_5555_6666_7777;
        endcase
    endfunction

    task automatic make_pkt(input logic [7:0] ttl, input logic [15:0] csum, input int ndata, input bit extra);
        pd.delete();
        pc.delete();
        if (extra) begin
            pd.push_back(64'hDEAD_BEEF_0000_0001);
            pc.push_back(8'hFE);
        end
        pd.push_back(64'h0000_0006_0001_0030);
        pc.push_back(8'hFF);
        for (int k = 1; k <= ndata; k++) begin
            pd.push_back(tmpl_word(k, ttl, csum));
            pc.push_back((k == ndata) ? 8'h80 : 8'h00);
        end
    endtask

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s > 65535) s = s - 65535;
        return s[15:0];
    endfunction

    // Model: header words until the first ctrl==0 word, then Ethernet/IP
    // words numbered from 1; only words 1..4 are ever edited.
    task automatic expect_pkt(input desc_t d);
        bit hdr;
        int k;
        logic [63:0] w;
        hdr = 1'b1;
        k = 0;
        mdl.delete();
        for (int i = 0; i < pd.size(); i++) begin
            w = pd[i];
            if (hdr && pc[i] != 8'h00) begin
                if (pc[i] == 8'hFF) w[63:48] = d.dst;
            end else begin
                hdr = 1'b0;
                k++;
                if (k == 1) w = {d.da, d.sa[47:32]};
                if (k == 2) w[63:32] = d.sa[31:0];
                if (k == 3 && TTL_EN && d.dec) w[15:8] = w[15:8] - 8'd1;
                if (k == 4 && TTL_EN && d.dec) w[63:48] = ones_add(w[63:48], 16'h0100);
            end
            mdl.push_back({pc[i], w});
            if (!d.drop) exp_q.push_back({pc[i], w});
        end
    endtask

    task automatic push_desc(input desc_t d);
        rw_wr = 1'b1;
        rw_dst_port = d.dst;
        rw_mac_dst = d.da;
        rw_mac_src = d.sa;
        rw_dec_ttl = d.dec;
        rw_drop = d.drop;
        @(posedge clk);
        #1;
        rw_wr = 1'b0;
    endtask

    task automatic drive_words(input int first, input int last);
        int i;
        int guard;
        bit acc;
        i = first;
        guard = 0;
        while (i <= last) begin
            in_wr = 1'b1;
            in_data = pd[i];
            in_ctrl = pc[i];
            if (bp_en) begin
                out_rdy = ((bp_cyc / 2) % 2) == 0;
                bp_cyc++;
            end
            @(negedge clk);
            if (bp_en) check64("in_rdy_tracks_out_rdy", {63'd0, in_rdy}, {63'd0, out_rdy});
            acc = in_rdy;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
            if (guard > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL drive_timeout: got %0d words accepted required %0d", i - first, last - first + 1);
                break;
            end
        end
        in_wr = 1'b0;
        out_rdy = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    desc_t d, dq[5];
    bit    exp_rdy;

    initial begin
        #1 reset = 1'b1;
        #1;
        check64("reset_out_wr", {63'd0, out_wr}, 64'd0);
        check64("reset_out_data", out_data, 64'd0);
        check64("reset_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        check64("reset_rw_in_rdy", {63'd0, rw_in_rdy}, 64'd1);
        check64("reset_in_rdy", {63'd0, in_rdy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single packet with TTL decrement
        d = '{dst: 16'h0004, da: 48'h0011_2233_4455, sa: 48'hAABB_CCDD_EE01, dec: 1'b1, drop: 1'b0};
        push_desc(d);
        make_pkt(8'h40, 16'hB861, 6, 1'b0);
        expect_pkt(d);
        check64("model_ioq_dst", {48'd0, mdl[0][63:48]}, 64'h0004);
        check64("model_w1", mdl[1][63:0], 64'h0011_2233_4455_AABB);
        check64("model_w2", mdl[2][63:0], 64'hCCDD_EE01_0800_4500);
        check64("model_ttl", {56'd0, mdl[3][15:8]}, TTL_EN ? 64'h3F : 64'h40);
        check64("model_csum", {48'd0, mdl[4][63:48]}, TTL_EN ? 64'hB961 : 64'hB861);
        cap.delete();
        drive_words(0, pd.size() - 1);
        settle();
        check64("p1_out_count", 64'(cap.size()), 64'd7);
        check64("p1_dut_ioq", cap[0][63:0], 64'h0004_0006_0001_0030);
        check64("p1_dut_ttl", {56'd0, cap[3][15:8]}, TTL_EN ? 64'h3F : 64'h40);
        check64("p1_dut_csum", {48'd0, cap[4][63:48]}, TTL_EN ? 64'hB961 : 64'hB861);

        // Checksum and TTL wrap
        d = '{dst: 16'h0002, da: 48'h0200_0000_0001, sa: 48'h0200_0000_0002, dec: 1'b1, drop: 1'b0};
        push_desc(d);
        make_pkt(8'h00, 16'hFF80, 6, 1'b0);
        expect_pkt(d);
        check64("model_ttl_wrap", {56'd0, mdl[3][15:8]}, TTL_EN ? 64'hFF : 64'h00);
        check64("model_csum_wrap", {48'd0, mdl[4][63:48]}, TTL_EN ? 64'h0081 : 64'hFF80);
        cap.delete();
        drive_words(0, pd.size() - 1);
        settle();
        check64("p2_dut_csum", {48'd0, cap[4][63:48]}, TTL_EN ? 64'h0081 : 64'hFF80);

        // Dropped packet followed by an intact one
        d = '{dst: 16'h0001, da: 48'h0A0A_0A0A_0A0A, sa: 48'h0B0B_0B0B_0B0B, dec: 1'b1, drop: 1'b1};
        push_desc(d);
        dq[0] = '{dst: 16'h0010, da: 48'h1234_5678_9ABC, sa: 48'hFEDC_BA98_7654, dec: 1'b0, drop: 1'b0};
        push_desc(dq[0]);
        make_pkt(8'h20, 16'h1234, 5, 1'b0);
        expect_pkt(d);
        drive_words(0, pd.size() - 1);
        make_pkt(8'h21, 16'h4321, 6, 1'b1);
        expect_pkt(dq[0]);
        cap.delete();
        drive_words(0, pd.size() - 1);
        settle();
        check64("drop_b_count", 64'(cap.size()), 64'd8);

        // Backpressure
        d = '{dst: 16'h0008, da: 48'h0000_0000_00C1, sa: 48'h0000_0000_00C2, dec: 1'b1, drop: 1'b0};
        push_desc(d);
        make_pkt(8'h80, 16'h0001, 6, 1'b0);
        expect_pkt(d);
        bp_en = 1'b1;
        drive_words(0, pd.size() - 1);
        bp_en = 1'b0;
        settle();

        // Descriptor starvation
        d = '{dst: 16'h0020, da: 48'h5555_5555_5555, sa: 48'h6666_6666_6666, dec: 1'b1, drop: 1'b0};
        make_pkt(8'h11, 16'hAAAA, 6, 1'b0);
        expect_pkt(d);
        in_wr = 1'b1;
        in_data = pd[0];
        in_ctrl = pc[0];
        repeat (4) begin
            @(negedge clk);
            check64("starve_in_rdy", {63'd0, in_rdy}, 64'd0);
            @(posedge clk);
            #1;
        end
        push_desc(d);
        drive_words(0, pd.size() - 1);
        settle();

        // Fill the queue, then drain it with four packets
        for (int i = 0; i < 5; i++) begin
            dq[i] = '{dst: 16'(1 << i), da: 48'h0100_0000_0000 + 48'(i), sa: 48'h0200_0000_0000 + 48'(i),
                      dec: (i != 1), drop: (i == 2)};
        end
        for (int i = 0; i < 4; i++) begin
            push_desc(dq[i]);
            exp_rdy = (i + 1) < 3;
            check64("fill_rw_in_rdy", {63'd0, rw_in_rdy}, {63'd0, exp_rdy});
        end
        push_desc(dq[4]);
        check64("full_rw_in_rdy", {63'd0, rw_in_rdy}, 64'd0);
        make_pkt(8'h05, 16'h0FFF, 6, 1'b0);
        expect_pkt(dq[0]);
        drive_words(0, pd.size() - 1);
        make_pkt(8'h06, 16'h1111, 3, 1'b0);
        expect_pkt(dq[1]);
        drive_words(0, pd.size() - 1);
        make_pkt(8'h07, 16'h2222, 6, 1'b0);
        expect_pkt(dq[2]);
        drive_words(0, pd.size() - 1);
        make_pkt(8'h08, 16'h3333, 6, 1'b1);
        expect_pkt(dq[3]);
        drive_words(0, pd.size() - 1);
        settle();
        check64("drained_rw_in_rdy", {63'd0, rw_in_rdy}, 64'd1);
        in_wr = 1'b1;
        in_data = pd[0];
        in_ctrl = pc[0];
        @(negedge clk);
        check64("full_push_ignored", {63'd0, in_rdy}, 64'd0);
        @(posedge clk);
        #1;
        in_wr = 1'b0;

        // Async reset while word 3 is presented
        d = '{dst: 16'h0040, da: 48'h7777_7777_7777, sa: 48'h8888_8888_8888, dec: 1'b1, drop: 1'b0};
        push_desc(d);
        make_pkt(8'h30, 16'h5555, 6, 1'b0);
        expect_pkt(d);
        drive_words(0, 2);
        in_wr = 1'b1;
        in_data = pd[3];
        in_ctrl = pc[3];
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check64("rst_mid_out_wr", {63'd0, out_wr}, 64'd0);
        check64("rst_mid_out_data", out_data, 64'd0);
        check64("rst_mid_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        check64("rst_mid_rw_in_rdy", {63'd0, rw_in_rdy}, 64'd1);
        exp_q.delete();
        in_wr = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        d = '{dst: 16'h0080, da: 48'h9999_9999_9999, sa: 48'hAAAA_AAAA_AAAA, dec: 1'b1, drop: 1'b0};
        push_desc(d);
        make_pkt(8'h40, 16'hB861, 6, 1'b0);
        expect_pkt(d);
        cap.delete();
        drive_words(0, pd.size() - 1);
        settle();
        check64("post_rst_count", 64'(cap.size()), 64'd7);

        check64("exp_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
